cond_logic_mc: RTL

COND_LOGIC_MC -- requirements
Module: cond_logic_mc

---
 rtl/cond_logic_mc.sv | 62 ++++++
 1 files changed

// File: rtl/cond_logic_mc.sv
// cond_logic_mc: ARM multicycle condition unit that gates writes with a latched condition and counts squashed instructions.
// Flags update only when the instruction's own condition passes.
module cond_logic_mc (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       NoWrite,
   input  logic       CondLatch,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NextPC,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags,
   output logic       CondEx,
   output logic [7:0] SkipCount
);
   logic condExReg;
   logic n, z, c, v;
   assign {n, z, c, v} = Flags;
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = z;
         4'b0001: CondEx = !z;
         4'b0010: CondEx = c;
         4'b0011: CondEx = !c;
         4'b0100: CondEx = n;
         4'b0101: CondEx = !n;
         4'b0110: CondEx = v;
         4'b0111: CondEx = !v;
         4'b1000: CondEx = c & !z;
         4'b1001: CondEx = !c | z;
         4'b1010: CondEx = n == v;
         4'b1011: CondEx = n != v;
         4'b1100: CondEx = !z & (n == v);
         4'b1101: CondEx = z | (n != v);
         4'b1110: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end
   // CondExReg samples CondEx from the pre-update Flags since both load on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         Flags     <= 4'b0000;
         condExReg <= 1'b0;
         SkipCount <= 8'h00;
      end else begin
         if (FlagW[1] && CondEx) Flags[3:2] <= ALUFlags[3:2];
         if (FlagW[0] && CondEx) Flags[1:0] <= ALUFlags[1:0];
         if (CondLatch) condExReg <= CondEx;
         if (CondLatch && !CondEx && SkipCount != 8'hFF) SkipCount <= SkipCount + 8'h01;
      end
   end
   assign RegWrite = RegW & condExReg & !NoWrite;
   assign MemWrite = MemW & condExReg;
   assign PCWrite  = (PCS & condExReg) | NextPC;
endmodule
